header_gen: RTL and testbench
=============================

Name: header_gen

Overview:
- Byte-stream frame transmitter; the sending end of the header-detect link.
- Emits a preamble of HDR_REPS repetitions of the pair 0x55, 0xD5, then forwards payload bytes from an upstream valid/ready source, then a fixed idle gap of 0x00 bytes.
- Output byte stream is continuous: one byte per clk, idle value 0x00. It feeds the header detector's din directly or through the link.

Parameters:
- HDR_REPS, 5, number of 0x55/0xD5 pairs per preamble (1..15).
- GAP_LEN, 2, idle 0x00 bytes forced after each frame (0..15).
- MAX_LEN, 64, maximum payload bytes per frame (1..255).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- s_data  input  8  payload byte from upstream.
- s_vld  input  1  s_data valid.
- s_last  input  1  marks the final payload byte of a frame; qualified by s_vld.
- s_rdy  output  1  payload byte accepted when s_vld && s_rdy.
- dout  output  8  transmitted byte stream.
- dout_vld  output  1  dout carries a preamble, payload or trailer byte.
- sof  output  1  one-cycle pulse with the first 0x55 of a preamble.
- eof  output  1  one-cycle pulse with the last byte of a frame.
- underrun  output  1  one-cycle pulse when the payload source stalls mid-frame.
- len_err  output  1  one-cycle pulse when a frame is truncated at MAX_LEN.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port rst.
- All outputs are registered. Reset values: dout=0x00, all other outputs 0. State on reset is IDLE, all counters 0.
- Reset mid-frame aborts the frame immediately. The next cycle outputs 0x00 with no eof.
- States: IDLE, H55, HD5, PAYLOAD, GAP (plus CSUM, see Optional Feature).
- IDLE: dout=0x00, dout_vld=0, s_rdy=0. If s_vld=1, the next state is H55; the upstream byte is held, not consumed.
- H55: dout=0x55, dout_vld=1. sof=1 on the first pair only. Next state is HD5.
- HD5: dout=0xD5, dout_vld=1. Increments rep_cnt. If rep_cnt==HDR_REPS-1, the next state is PAYLOAD; otherwise H55.
  - The preamble always spans exactly 2*HDR_REPS cycles with no interruption.
- PAYLOAD: s_rdy=1 combinationally from state, i.e. s_rdy is the registered state decode.
  - On a transfer, the byte appears on dout the next cycle with dout_vld=1, and len_cnt increments.
  - If s_vld=0: dout=0x00, dout_vld=0, underrun=1. Remain in PAYLOAD.
  - Transfer with s_last=1: that byte is output with eof=1, and the state goes to GAP.
  - Transfer with len_cnt==MAX_LEN-1 and s_last=0: the byte is output with eof=1 and len_err=1, then GAP.
    - Upstream bytes up to and including the next s_last are then dropped: s_rdy=1 in IDLE, with discard until s_last.
    - After discard, the next frame starts normally.
- GAP: dout=0x00, dout_vld=0 for GAP_LEN cycles, then IDLE. If GAP_LEN=0, go directly to IDLE.
  - A new s_vld is not accepted during GAP.
- Back-to-back frames: minimum spacing is one IDLE cycle plus GAP_LEN.
- Arithmetic: rep_cnt is 4 bits and len_cnt is 8 bits. Both clear on frame start; neither wraps.

Optional Feature:
- Macro: HEADER_GEN_CSUM_EN.
- Defined: a CSUM state follows the last payload byte. It emits one byte equal to the XOR of all payload bytes, with dout_vld=1.
  - eof moves to the checksum byte.
  - The running XOR clears on sof.
- Undefined: no CSUM state or XOR register; eof is on the last payload byte.

Decomposition:
- Package header_gen_pkg holds:
  - HDR_BYTE0=8'h55, HDR_BYTE1=8'hD5, IDLE_BYTE=8'h00.
  - State encoding localparams: 3-bit, IDLE=0, H55=1, HD5=2, PAYLOAD=3, GAP=4, CSUM=5.
- No sub-module. The FSM, counters and output register live in one module.

Test Plan:
- Reset then s_vld=0 for 10 cycles -> dout=0x00, dout_vld=0, s_rdy=0 throughout.
- Default params, one 3-byte frame (0x11, 0x22, 0x33 with s_last) -> output is 0x55,0xD5 ×5, then 0x11,0x22,0x33, then 0x00 ×2.
  - sof on cycle 1 of the preamble; eof with 0x33.
  - The header detector instance reaches its 5-pair count.
- Upstream stalls 2 cycles after the first payload byte -> two 0x00 bytes with dout_vld=0 and two underrun pulses, then the frame resumes.
- MAX_LEN=4, 6-byte frame -> 4 payload bytes output, eof and len_err on the 4th; bytes 5-6 dropped.
  - The next frame starts with a clean preamble.
- rst asserted during the 3rd preamble pair -> 0x00 the next cycle. A following frame emits the full 5 pairs.
- HEADER_GEN_CSUM_EN defined, payload 0x0F,0xF0,0x01 -> trailer byte 0xFE with eof=1.

Source files
------------

// File: rtl/header_gen_pkg.sv
// Shared constants and state encoding for the header_gen frame transmitter.
package header_gen_pkg;

  localparam logic [7:0] HDR_BYTE0 = 8'h55;
  localparam logic [7:0] HDR_BYTE1 = 8'hD5;
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  // Fixed 3-bit encodings so traces line up with the receiving end's decoder.
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] H55     = 3'd1;
  localparam logic [2:0] HD5     = 3'd2;
  localparam logic [2:0] PAYLOAD = 3'd3;
  localparam logic [2:0] GAP     = 3'd4;
  localparam logic [2:0] CSUM    = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = IDLE,
    StH55     = H55,
    StHd5     = HD5,
    StPayload = PAYLOAD,
    StGap     = GAP,
    StCsum    = CSUM
  } state_t;

endpackage

// File: rtl/header_gen.sv
// Byte-stream frame transmitter: preamble of HDR_REPS 0x55/0xD5 pairs, payload forwarded from a
// valid/ready source, then GAP_LEN idle bytes. Frames longer than MAX_LEN are truncated and the
// rest of the upstream frame is discarded.
// Optional feature: define HEADER_GEN_CSUM_EN to append an XOR checksum byte after the payload.
module header_gen
  import header_gen_pkg::*;
#(
  parameter int unsigned HDR_REPS = 5,
  parameter int unsigned GAP_LEN  = 2,
  parameter int unsigned MAX_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_data,
  input  logic       s_vld,
  input  logic       s_last,
  output logic       s_rdy,
  output logic [7:0] dout,
  output logic       dout_vld,
  output logic       sof,
  output logic       eof,
  output logic       underrun,
  output logic       len_err
);

  localparam logic [3:0] RepLast  = 4'(HDR_REPS - 1);
  localparam logic [3:0] GapLast  = 4'(GAP_LEN - 1);
  localparam logic [7:0] LenLast  = 8'(MAX_LEN - 1);
  // With no gap the frame goes straight back to idle.
  localparam state_t     EndState = (GAP_LEN == 0) ? StIdle : StGap;

  state_t     state_q, state_d;
  logic [3:0] rep_q, rep_d;
  logic [3:0] gap_q, gap_d;
  logic [7:0] len_q, len_d;
  logic       discard_q, discard_d;

  logic [7:0] dout_q, dout_d;
  logic       vld_q, vld_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       under_q, under_d;
  logic       lerr_q, lerr_d;
  logic       rdy_q, rdy_d;

`ifdef HEADER_GEN_CSUM_EN
  logic [7:0] csum_q, csum_d;
`endif

  logic xfer;
  assign xfer = s_vld & rdy_q;

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d   = state_q;
    rep_d     = rep_q;
    gap_d     = gap_q;
    len_d     = len_q;
    discard_d = discard_q;
    dout_d    = IDLE_BYTE;
    vld_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    under_d   = 1'b0;
    lerr_d    = 1'b0;
`ifdef HEADER_GEN_CSUM_EN
    csum_d    = csum_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (discard_q) begin
          // Drain the tail of a truncated frame; the start byte is never consumed here.
          if (xfer && s_last) discard_d = 1'b0;
        end else if (s_vld) begin
          state_d = StH55;
          rep_d   = '0;
          len_d   = '0;
        end
      end
      StH55: begin
        dout_d  = HDR_BYTE0;
        vld_d   = 1'b1;
        sof_d   = (rep_q == 4'd0);
`ifdef HEADER_GEN_CSUM_EN
        if (rep_q == 4'd0) csum_d = '0;
`endif
        state_d = StHd5;
      end
      StHd5: begin
        dout_d  = HDR_BYTE1;
        vld_d   = 1'b1;
        rep_d   = rep_q + 4'd1;
        state_d = (rep_q == RepLast) ? StPayload : StH55;
      end
      StPayload: begin
        if (xfer) begin
          dout_d = s_data;
          vld_d  = 1'b1;
          len_d  = len_q + 8'd1;
`ifdef HEADER_GEN_CSUM_EN
          csum_d = csum_q ^ s_data;
`endif
          if (s_last || (len_q == LenLast)) begin
            lerr_d    = ~s_last;
            discard_d = ~s_last;
`ifdef HEADER_GEN_CSUM_EN
            state_d   = StCsum;
`else
            eof_d     = 1'b1;
            state_d   = EndState;
            gap_d     = '0;
`endif
          end
        end else begin
          under_d = 1'b1;
        end
      end
`ifdef HEADER_GEN_CSUM_EN
      StCsum: begin
        dout_d  = csum_q;
        vld_d   = 1'b1;
        eof_d   = 1'b1;
        state_d = EndState;
        gap_d   = '0;
      end
`endif
      StGap: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == GapLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Ready is a decode of the state being entered, so it is registered alongside it.
    rdy_d = (state_d == StPayload) || ((state_d == StIdle) && discard_d);
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rep_q     <= '0;
      gap_q     <= '0;
      len_q     <= '0;
      discard_q <= 1'b0;
      dout_q    <= IDLE_BYTE;
      vld_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      under_q   <= 1'b0;
      lerr_q    <= 1'b0;
      rdy_q     <= 1'b0;
`ifdef HEADER_GEN_CSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      len_q     <= len_d;
      discard_q <= discard_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      under_q   <= under_d;
      lerr_q    <= lerr_d;
      rdy_q     <= rdy_d;
`ifdef HEADER_GEN_CSUM_EN
      csum_q    <= csum_d;
`endif
    end
  end

  assign s_rdy    = rdy_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
  assign sof      = sof_q;
  assign eof      = eof_q;
  assign underrun = under_q;
  assign len_err  = lerr_q;

endmodule

// File: tb/tb_header_gen.sv
// Self-checking bench for header_gen: frame-level reference model fed by directed and random
// frames, including stalls, MAX_LEN truncation and a mid-preamble reset.
module tb_header_gen;

  localparam int unsigned HdrReps = 5;
  localparam int unsigned GapLen  = 2;
  localparam int unsigned MaxLen  = 4;
`ifdef HEADER_GEN_CSUM_EN
  localparam bit CsumEn = 1'b1;
`else
  localparam bit CsumEn = 1'b0;
`endif

  logic       clk, rst;
  logic [7:0] s_data;
  logic       s_vld, s_last, s_rdy;
  logic [7:0] dout;
  logic       dout_vld, sof, eof, underrun, len_err;

  int errors = 0;
  int checks = 0;

  typedef struct {logic [7:0] d; logic v, s, e, u, l;} obs_t;
  typedef struct {logic [7:0] d; logic s, e, l, pre; int f;} exp_t;
  typedef logic [7:0] bytes_t[$];
  typedef int ints_t[$];

  // Stimulus description: flat byte/stall lists plus per-frame length and lead-in idle cycles.
  logic [7:0] pay[$];
  int         stall[$];
  int         flen[$];
  int         fpre[$];

  header_gen #(
    .HDR_REPS(HdrReps),
    .GAP_LEN (GapLen),
    .MAX_LEN (MaxLen)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_vld   (s_vld),
    .s_last  (s_last),
    .s_rdy   (s_rdy),
    .dout    (dout),
    .dout_vld(dout_vld),
    .sof     (sof),
    .eof     (eof),
    .underrun(underrun),
    .len_err (len_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add_frame(input bytes_t b, input ints_t st, input int pre);
    for (int i = 0; i < b.size(); i++) begin
      pay.push_back(b[i]);
      stall.push_back(st[i]);
    end
    flen.push_back(b.size());
    fpre.push_back(pre);
  endtask

  task automatic test_reset;
    rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout, dout_vld, sof, eof, underrun, len_err, s_rdy} !== 14'h0) begin
      errors++;
      $display("FAIL reset_value: got dout=%02h vld=%b sof=%b eof=%b und=%b lerr=%b rdy=%b, required all 0",
               dout, dout_vld, sof, eof, underrun, len_err, s_rdy);
    end
    rst = 1'b0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      checks++;
      if (dout !== 8'h00 || dout_vld !== 1'b0 || s_rdy !== 1'b0) begin
        errors++;
        $display("FAIL idle_after_reset: cycle %0d got dout=%02h vld=%b rdy=%b, required 00/0/0",
                 t, dout, dout_vld, s_rdy);
      end
    end
  endtask

  task automatic drive_all;
    int k = 0;
    bit got;
    int t;
    for (int f = 0; f < flen.size(); f++) begin
      repeat (fpre[f]) begin @(posedge clk); #1; end
      for (int i = 0; i < flen[f]; i++) begin
        s_data = pay[k+i]; s_vld = 1'b1; s_last = (i == flen[f] - 1);
        got = 1'b0; t = 0;
        while (!got && t < 200) begin @(negedge clk); got = (s_rdy === 1'b1); t++; end
        if (!got) begin
          errors++; checks++;
          $display("FAIL handshake_timeout: frame %0d byte %0d got s_rdy=0 for 200 cycles, required 1",
                   f, i);
          s_vld = 1'b0; s_last = 1'b0;
          return;
        end
        @(posedge clk); #1;
        s_vld = 1'b0; s_last = 1'b0;
        if (i < flen[f] - 1) repeat (stall[k+i]) begin @(posedge clk); #1; end
      end
      k += flen[f];
    end
  endtask

  task automatic test_stream;
    bytes_t b;
    ints_t  st;
    obs_t   obs[$];
    obs_t   o;
    exp_t   expq[$];
    exp_t   e;
    int     exp_under[$];
    int     got_under[$];
    bit     exact[$];
    bit     mon_on;
    int     k, eff, cur_f, idle_run;
    logic [7:0] x;
    bit     prev_v;

    pay.delete(); stall.delete(); flen.delete(); fpre.delete();
    b = {8'h11, 8'h22, 8'h33};                      st = {0, 0, 0};          add_frame(b, st, 0);
    b = {8'hA1, 8'hB2, 8'hC3};                      st = {2, 0, 0};          add_frame(b, st, 0);
    b = {8'h40, 8'h41, 8'h42, 8'h43};               st = {0, 0, 0, 0};       add_frame(b, st, 0);
    b = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; st = {0, 1, 0, 0, 1, 0}; add_frame(b, st, 0);
    b = {8'h0F, 8'hF0, 8'h01};                      st = {0, 0, 0};          add_frame(b, st, 0);
    for (int f = 0; f < 14; f++) begin
      b.delete(); st.delete();
      for (int i = 0; i < int'($urandom_range(1, 7)); i++) begin
        b.push_back(8'($urandom));
        st.push_back(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      end
      add_frame(b, st, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    // Reference model: expected transmitted bytes per frame from the framing rules.
    k = 0;
    for (int f = 0; f < flen.size(); f++) begin
      eff = (flen[f] > int'(MaxLen)) ? int'(MaxLen) : flen[f];
      for (int r = 0; r < int'(HdrReps); r++) begin
        expq.push_back('{d: 8'h55, s: (r == 0), e: 1'b0, l: 1'b0, pre: 1'b1, f: f});
        expq.push_back('{d: 8'hD5, s: 1'b0, e: 1'b0, l: 1'b0, pre: 1'b1, f: f});
      end
      x = 8'h00;
      exp_under.push_back(0);
      for (int i = 0; i < eff; i++) begin
        x ^= pay[k+i];
        expq.push_back('{d: pay[k+i], s: 1'b0, e: (!CsumEn && i == eff - 1),
                         l: (i == eff - 1 && flen[f] > int'(MaxLen)), pre: 1'b0, f: f});
        if (i < eff - 1) exp_under[f] += stall[k+i];
      end
      if (CsumEn) expq.push_back('{d: x, s: 1'b0, e: 1'b1, l: 1'b0, pre: 1'b0, f: f});
      exact.push_back(f > 0 && fpre[f] == 0 && flen[f-1] <= int'(MaxLen));
      got_under.push_back(0);
      k += flen[f];
    end

    mon_on = 1'b1;
    fork
      begin
        drive_all();
        repeat (15) @(posedge clk);
        mon_on = 1'b0;
      end
      begin
        while (mon_on) begin
          @(negedge clk);
          o.d = dout; o.v = dout_vld; o.s = sof; o.e = eof; o.u = underrun; o.l = len_err;
          obs.push_back(o);
        end
      end
    join

    cur_f = -1; idle_run = 0; prev_v = 1'b0;
    for (int n = 0; n < obs.size(); n++) begin
      o = obs[n];
      if (o.v === 1'b1) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL stream_extra: cycle %0d got byte %02h, required no further frame bytes", n, o.d);
        end else begin
          e = expq.pop_front();
          if ({o.d, o.s, o.e, o.l, o.u} !== {e.d, e.s, e.e, e.l, 1'b0}) begin
            errors++;
            $display("FAIL stream_byte: frame %0d cycle %0d got d=%02h sof=%b eof=%b lerr=%b und=%b, required d=%02h sof=%b eof=%b lerr=%b und=0",
                     e.f, n, o.d, o.s, o.e, o.l, o.u, e.d, e.s, e.e, e.l);
          end
          if (e.s) begin
            cur_f = e.f;
            if (e.f > 0) begin
              checks++;
              if (exact[e.f] ? (idle_run != int'(GapLen) + 1) : (idle_run < int'(GapLen) + 1)) begin
                errors++;
                $display("FAIL frame_spacing: frame %0d got %0d idle cycles, required %s%0d",
                         e.f, idle_run, exact[e.f] ? "" : ">=", GapLen + 1);
              end
            end
          end else if (e.pre) begin
            checks++;
            if (!prev_v) begin
              errors++;
              $display("FAIL preamble_gap: frame %0d cycle %0d got idle before preamble byte, required none",
                       e.f, n);
            end
          end
        end
        idle_run = 0;
      end else begin
        checks++;
        if (o.v !== 1'b0 || o.d !== 8'h00 || o.s !== 1'b0 || o.e !== 1'b0 || o.l !== 1'b0) begin
          errors++;
          $display("FAIL stream_idle: cycle %0d got d=%02h vld=%b sof=%b eof=%b lerr=%b, required 00 with flags 0",
                   n, o.d, o.v, o.s, o.e, o.l);
        end
        if (o.u === 1'b1) begin
          if (cur_f >= 0) got_under[cur_f]++;
          else begin
            errors++;
            $display("FAIL underrun_outside: cycle %0d got underrun=1, required 0", n);
          end
        end
        idle_run++;
      end
      prev_v = (o.v === 1'b1);
    end

    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL stream_missing: got %0d bytes short, required 0", expq.size());
    end
    for (int f = 0; f < flen.size(); f++) begin
      checks++;
      if (got_under[f] != exp_under[f]) begin
        errors++;
        $display("FAIL underrun_count: frame %0d got %0d pulses, required %0d", f, got_under[f],
                 exp_under[f]);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] want[$];
    obs_t got[$];
    obs_t o;
    bit found = 1'b0;
    bit done = 1'b0;
    bit seen = 1'b0;
    bit gapless = 1'b1;
    logic prev = 1'b0;

    s_data = 8'hA5; s_vld = 1'b1; s_last = 1'b1;
    for (int t = 0; t < 10 && !found; t++) begin @(negedge clk); found = (sof === 1'b1); end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_start: got no sof within 10 cycles, required sof");
      s_vld = 1'b0; s_last = 1'b0;
      return;
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (dout !== 8'h55 || dout_vld !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pair3: got dout=%02h vld=%b, required 55/1", dout, dout_vld);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({dout, dout_vld, sof, eof, s_rdy} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset_abort: got dout=%02h vld=%b sof=%b eof=%b rdy=%b, required all 0",
               dout, dout_vld, sof, eof, s_rdy);
    end
    rst = 1'b0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      if (dout_vld === 1'b1) begin
        o.d = dout; o.v = 1'b1; o.s = sof; o.e = eof; o.u = underrun; o.l = len_err;
        got.push_back(o);
        if (seen && !prev) gapless = 1'b0;
        seen = 1'b1;
        done = (eof === 1'b1);
      end
      prev = dout_vld;
      if (s_rdy === 1'b1 && s_vld === 1'b1) begin
        @(posedge clk); #1;
        s_vld = 1'b0; s_last = 1'b0;
      end
    end
    s_vld = 1'b0; s_last = 1'b0;

    for (int r = 0; r < int'(HdrReps); r++) begin want.push_back(8'h55); want.push_back(8'hD5); end
    want.push_back(8'hA5);
    if (CsumEn) want.push_back(8'hA5);

    checks++;
    if (got.size() != want.size()) begin
      errors++;
      $display("FAIL mid_reset_len: got %0d frame bytes, required %0d", got.size(), want.size());
    end
    for (int n = 0; n < want.size() && n < got.size(); n++) begin
      checks++;
      if (got[n].d !== want[n] || got[n].s !== (n == 0) || got[n].e !== (n == want.size() - 1)) begin
        errors++;
        $display("FAIL mid_reset_byte: index %0d got d=%02h sof=%b eof=%b, required d=%02h sof=%b eof=%b",
                 n, got[n].d, got[n].s, got[n].e, want[n], (n == 0), (n == want.size() - 1));
      end
    end
    checks++;
    if (!gapless) begin
      errors++;
      $display("FAIL mid_reset_gapless: got idle cycle inside frame, required none");
    end
  endtask

  initial begin
    rst = 1'b1; s_vld = 1'b0; s_last = 1'b0; s_data = 8'h00;
    test_reset();
    test_stream();
    test_mid_reset();
    repeat (5) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
